// File: rtl/seq_divider8.sv
// seq_divider8: sequential unsigned restoring divider, 16-bit / 8-bit -> 8-bit
// quotient + 8-bit remainder, with a start/busy/done handshake.
// Define SEQ_DIV_RADIX4_EN to retire two quotient bits per RUN cycle
// (4 iterations instead of 8). Results and error timing are unchanged.
module seq_divider8 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [7:0]  quotient,
    output logic [7:0]  remainder,
    output logic        div_by_zero,
    output logic        overflow
);

`ifdef SEQ_DIV_RADIX4_EN
    localparam logic [2:0] LAST_ITER = 3'd3;
`else
    localparam logic [2:0] LAST_ITER = 3'd7;
`endif

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state_q, state_d;
    // Between iterations R < divisor, so the stored partial remainder needs
    // only 8 bits; its ninth bit exists only transiently after the shift.
    logic [7:0]  r_q, r_d;
    logic [7:0]  q_q, q_d;
    logic [7:0]  dvs_q, dvs_d;
    logic [2:0]  cnt_q, cnt_d;
    // Error detected at the start edge; reported one cycle later so that the
    // error path also sees done after edge 1.
    logic        pend_dz_q, pend_dz_d;
    logic        pend_ov_q, pend_ov_d;
    logic [7:0]  quot_q, quot_d;
    logic [7:0]  rem_q, rem_d;
    logic        dz_q, dz_d;
    logic        ov_q, ov_d;
    logic [15:0] step;

    // One restoring step: shift {R,Q} left, subtract divisor if it fits.
    function automatic logic [15:0] div_step(input logic [7:0] r,
                                             input logic [7:0] q,
                                             input logic [7:0] d);
        logic [8:0] sh;
        logic [7:0] rn;
        logic       fits;
        sh   = {r, q[7]};
        fits = (sh >= {1'b0, d});
        // The true difference is < divisor when it fits, so 8 bits suffice.
        rn   = fits ? (sh[7:0] - d) : sh[7:0];
        return {rn, q[6:0], fits};
    endfunction

    // Combinational datapath step; radix-4 cascades two steps, MSB first.
    always_comb begin
`ifdef SEQ_DIV_RADIX4_EN
        logic [15:0] s1;
        s1   = div_step(r_q, q_q, dvs_q);
        step = div_step(s1[15:8], s1[7:0], dvs_q);
`else
        step = div_step(r_q, q_q, dvs_q);
`endif
    end

    // Next-state and next-datapath logic.
    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        q_d       = q_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        pend_dz_d = pend_dz_q;
        pend_ov_d = pend_ov_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        dz_d      = dz_q;
        ov_d      = ov_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    dvs_d   = divisor;
                    cnt_d   = 3'd0;
                    if (divisor == 8'd0) begin
                        pend_dz_d = 1'b1;
                        pend_ov_d = 1'b0;
                    end else if (dividend[15:8] >= divisor) begin
                        pend_dz_d = 1'b0;
                        pend_ov_d = 1'b1;
                    end else begin
                        pend_dz_d = 1'b0;
                        pend_ov_d = 1'b0;
                        r_d       = dividend[15:8];
                        q_d       = dividend[7:0];
                        dz_d      = 1'b0;
                        ov_d      = 1'b0;
                    end
                end
            end
            RUN: begin
                if (pend_dz_q || pend_ov_q) begin
                    state_d = DONE;
                    quot_d  = 8'hFF;
                    rem_d   = 8'h00;
                    dz_d    = pend_dz_q;
                    ov_d    = pend_ov_q;
                end else begin
                    r_d   = step[15:8];
                    q_d   = step[7:0];
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == LAST_ITER) begin
                        state_d = DONE;
                        quot_d  = step[7:0];
                        rem_d   = step[15:8];
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            r_q       <= '0;
            q_q       <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            pend_dz_q <= 1'b0;
            pend_ov_q <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            dz_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            r_q       <= r_d;
            q_q       <= q_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            pend_dz_q <= pend_dz_d;
            pend_ov_q <= pend_ov_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            dz_q      <= dz_d;
            ov_q      <= ov_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dz_q;
    assign overflow    = ov_q;

endmodule
